// File: rtl/execute_stage.sv
// Execute stage: ALU (add/sub/and) with one-cycle latency plus a multi-cycle
// multiplier, with downstream stall holding, flush and synchronous reset.
module execute_stage #(
  parameter int unsigned WORD_WIDTH           = 32,
  parameter int unsigned REGISTER_INDEX_WIDTH = 5,
  parameter int unsigned OFFSET_SIZE          = 12,
  parameter int unsigned MUL_LATENCY          = 4,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTRUCTION = WORD_WIDTH'(32'h00000013)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_WIDTH-1:0]           instruction_in,
  input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
  input  logic [WORD_WIDTH-1:0]           first_input_in,
  input  logic [WORD_WIDTH-1:0]           second_input_in,
  input  logic [OFFSET_SIZE-1:0]          offset_in,
  input  logic [1:0]                      cu_alu_op_in,
  input  logic                            cu_is_imm_in,
  input  logic                            cu_branch_in,
  input  logic                            cu_reg_write_in,
  input  logic                            cu_mem_to_reg_in,
  input  logic                            cu_d_cache_access_in,
  input  logic                            cu_d_cache_op_in,
  input  logic                            cu_is_byte_op_in,
  input  logic                            stall_in,
  input  logic                            flush_in,
  output logic                            execution_empty,
  output logic [WORD_WIDTH-1:0]           result_out,
  output logic [WORD_WIDTH-1:0]           store_data_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
  output logic [WORD_WIDTH-1:0]           instruction_out,
  output logic                            valid_out,
  output logic                            branch_taken_out,
  output logic                            cu_branch_out,
  output logic                            cu_reg_write_out,
  output logic                            cu_mem_to_reg_out,
  output logic                            cu_d_cache_access_out,
  output logic                            cu_d_cache_op_out,
  output logic                            cu_is_byte_op_out
);

  localparam int unsigned CNT_W  = $clog2(MUL_LATENCY);
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned EXT_W  = WORD_WIDTH - OFFSET_SIZE;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [WORD_WIDTH-1:0]           op_a_q, op_b_q;
  logic [WORD_WIDTH-1:0]           pend_instr_q, pend_store_q;
  logic [REGISTER_INDEX_WIDTH-1:0] pend_dest_q;
  logic [CTRL_W-1:0]               pend_ctrl_q, ctrl_q;
  logic                            pend_branch_q;

  logic [WORD_WIDTH-1:0] operand_b, alu_result, product;
  logic [CTRL_W-1:0]     ctrl_in;
  logic                  is_nop, is_mul, branch_in, mul_done;

  // Operand selection and single-cycle ALU
  always_comb begin
    operand_b = cu_is_imm_in ? {{EXT_W{offset_in[OFFSET_SIZE-1]}}, offset_in} : second_input_in;
    is_nop    = (instruction_in == NOP_INSTRUCTION);
    is_mul    = (cu_alu_op_in == 2'b10) && !is_nop;
    branch_in = cu_branch_in && (first_input_in == second_input_in) && !is_nop;
    ctrl_in   = {cu_branch_in, cu_reg_write_in, cu_mem_to_reg_in,
                 cu_d_cache_access_in, cu_d_cache_op_in, cu_is_byte_op_in};
    case (cu_alu_op_in)
      2'b00:   alu_result = first_input_in + operand_b;
      2'b01:   alu_result = first_input_in - operand_b;
      2'b11:   alu_result = first_input_in & operand_b;
      default: alu_result = '0;
    endcase
    product  = op_a_q * op_b_q;
    mul_done = !stall_in && (state_q == HOLD || (state_q == MUL_BUSY && cnt_q == '0));
  end

  assign execution_empty = (state_q == IDLE) && !stall_in;
  assign {cu_branch_out, cu_reg_write_out, cu_mem_to_reg_out,
          cu_d_cache_access_out, cu_d_cache_op_out, cu_is_byte_op_out} = ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                  <= IDLE;
      cnt_q                    <= '0;
      result_out               <= '0;
      store_data_out           <= '0;
      destination_register_out <= '0;
      instruction_out          <= NOP_INSTRUCTION;
      valid_out                <= 1'b0;
      branch_taken_out         <= 1'b0;
      ctrl_q                   <= '0;
    end else if (flush_in) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      instruction_out  <= NOP_INSTRUCTION;
      valid_out        <= 1'b0;
      branch_taken_out <= 1'b0;
      ctrl_q           <= '0;
    end else begin
      if (state_q == IDLE && !stall_in) begin
        if (is_mul) begin
          op_a_q        <= first_input_in;
          op_b_q        <= operand_b;
          pend_instr_q  <= instruction_in;
          pend_store_q  <= second_input_in;
          pend_dest_q   <= destination_register_in;
          pend_ctrl_q   <= ctrl_in;
          pend_branch_q <= branch_in;
          cnt_q         <= CNT_W'(MUL_LATENCY - 1);
          state_q       <= MUL_BUSY;
          valid_out     <= 1'b0;
        end else begin
          result_out               <= alu_result;
          store_data_out           <= second_input_in;
          destination_register_out <= destination_register_in;
          instruction_out          <= instruction_in;
          valid_out                <= !is_nop;
          branch_taken_out         <= branch_in;
          ctrl_q                   <= is_nop ? '0 : ctrl_in;
        end
      end
      // Counter runs even under stall; completion under stall parks in HOLD
      if (state_q == MUL_BUSY) begin
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        else if (stall_in) state_q <= HOLD;
      end
      if (mul_done) begin
        result_out               <= product;
        store_data_out           <= pend_store_q;
        destination_register_out <= pend_dest_q;
        instruction_out          <= pend_instr_q;
        valid_out                <= 1'b1;
        branch_taken_out         <= pend_branch_q;
        ctrl_q                   <= pend_ctrl_q;
        state_q                  <= IDLE;
      end
    end
  end

endmodule
